fixp_acc_rr_arb: RTL and testbench

Packet-locked round-robin arbiter sharing one fixed-point accelerator datapath (normalizer/first-bit stage of `fixp_acc`) among `NUM_REQ` AXI-Stream-style requesters. It selects the next requester at or after a rotating pointer and holds the grant until that requester's `last` beat. It forwards data plus the winner's index to the shared unit. It sits in `box_250mhz` between per-lane request sources and the single `fixp_acc` datapath instance.

---
 rtl/fixp_acc_pkg.sv | 17 +
 rtl/fixp_acc_rr_arb_if.sv | 26 ++
 rtl/fixp_rr_pick.sv | 28 ++
 rtl/fixp_acc_rr_arb.sv | 125 ++++++++++++
 tb/tb_fixp_acc_rr_arb.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fixp_acc_pkg.sv
// Shared types and helpers for the fixp_acc arbiter slice.
package fixp_acc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Index width for n items, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/fixp_acc_rr_arb_if.sv
// Requester-side and datapath-side stream signals of the fixp_acc arbiter.
interface fixp_acc_rr_arb_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = fixp_acc_pkg::clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            s_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
    logic [NUM_REQ-1:0]            s_last;
    logic [NUM_REQ-1:0]            s_ready;
    logic                          m_valid;
    logic [DATA_WIDTH-1:0]         m_data;
    logic                          m_last;
    logic [ID_WIDTH-1:0]           m_id;
    logic                          m_ready;

    // master: requesters plus shared datapath; slave: the arbiter itself
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_id
    );
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_id
    );
endinterface

// File: rtl/fixp_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping around.
module fixp_rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] idx,
    output logic                found
);
    localparam int unsigned SUM_WIDTH = ID_WIDTH + 1;

    logic [NUM_REQ-1:0]   rot;
    logic [ID_WIDTH-1:0]  ofs;
    logic [SUM_WIDTH-1:0] sum;

    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        ofs = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) ofs = ID_WIDTH'(i);
        end
        sum   = SUM_WIDTH'(ptr) + SUM_WIDTH'(ofs);
        idx   = (sum >= SUM_WIDTH'(NUM_REQ)) ? ID_WIDTH'(sum - SUM_WIDTH'(NUM_REQ))
                                             : ID_WIDTH'(sum);
        found = |req;
    end
endmodule

// File: rtl/fixp_acc_rr_arb.sv
// Packet-locked round-robin arbiter in front of the shared fixp_acc datapath.
// FIXP_ARB_OUT_REG_EN adds a registered 2-entry skid buffer on the datapath side.
module fixp_acc_rr_arb
    import fixp_acc_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    fixp_acc_rr_arb_if.slave  bus,
    output logic              busy
);
    localparam int unsigned ID_WIDTH = clog2(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e            state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   pick_id;
    logic                  pick_found;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  ready_sel;
    logic                  accept;

    fixp_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req   (bus.s_valid),
        .ptr   (rr_ptr),
        .idx   (pick_id),
        .found (pick_found)
    );

    assign busy      = (state == BUSY);
    assign sel_valid = bus.s_valid[grant_id];
    assign sel_last  = bus.s_last[grant_id];
    assign sel_data  = bus.s_data[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
    assign accept    = busy && sel_valid && ready_sel;

    // Grant is held until the granted requester's last beat is accepted.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && sel_last) begin
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.s_ready = '0;
        if (busy && ready_sel) bus.s_ready[grant_id] = 1'b1;
    end

`ifdef FIXP_ARB_OUT_REG_EN
    logic                  v0, v1;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic                  l0, l1;
    logic [ID_WIDTH-1:0]   i0, i1;
    logic                  pop;

    assign ready_sel = !v1;
    assign pop       = v0 && bus.m_ready;

    // Entry 0 is the head and drives the datapath; entry 1 absorbs one stall.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            v0 <= 1'b0; d0 <= '0; l0 <= 1'b0; i0 <= '0;
            v1 <= 1'b0; d1 <= '0; l1 <= 1'b0; i1 <= '0;
        end else if (accept && !pop) begin
            if (!v0) begin
                v0 <= 1'b1; d0 <= sel_data; l0 <= sel_last; i0 <= grant_id;
            end else begin
                v1 <= 1'b1; d1 <= sel_data; l1 <= sel_last; i1 <= grant_id;
            end
        end else if (!accept && pop) begin
            v0 <= v1; d0 <= d1; l0 <= l1; i0 <= i1;
            v1 <= 1'b0;
        end else if (accept && pop) begin
            if (v1) begin
                d0 <= d1; l0 <= l1; i0 <= i1;
                d1 <= sel_data; l1 <= sel_last; i1 <= grant_id;
            end else begin
                d0 <= sel_data; l0 <= sel_last; i0 <= grant_id;
            end
        end
    end

    always_comb begin
        bus.m_valid = v0;
        bus.m_data  = d0;
        bus.m_last  = l0;
        bus.m_id    = i0;
    end
`else
    assign ready_sel = bus.m_ready;

    always_comb begin
        bus.m_valid = busy && sel_valid;
        bus.m_data  = busy ? sel_data : '0;
        bus.m_last  = busy && sel_last;
        bus.m_id    = grant_id;
    end
`endif

endmodule

// File: tb/tb_fixp_acc_rr_arb.sv
// Bench for fixp_acc_rr_arb (default build): vector table, directed corner cases,
// then random traffic against a cycle-level reference model.
module tb_fixp_acc_rr_arb;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    fixp_acc_rr_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fixp_acc_rr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .bus          (bus),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  sv;
        logic [N-1:0]  sl;
        logic          mr;
        logic          ev;
        logic [IW-1:0] eid;
        logic [N-1:0]  er;
        logic          eb;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [DW-1:0] lane_word(input int i, input int k);
        return {4'hA, 4'(i), 8'h00, 16'(k)};
    endfunction

    task automatic drive(input logic [N-1:0] sv, input logic [N-1:0] sl,
                         input logic mr, input int tag);
        bus.s_valid = sv;
        bus.s_last  = sl;
        bus.m_ready = mr;
        for (int i = 0; i < N; i++) bus.s_data[i*DW +: DW] = lane_word(i, tag);
    endtask

    task automatic check(input string name, input logic mv, input logic [DW-1:0] md,
                         input logic ml, input logic [IW-1:0] mid,
                         input logic [N-1:0] sr, input logic bz);
        checks++;
        if (bus.m_valid !== mv || bus.m_data !== md || bus.m_last !== ml ||
            bus.m_id !== mid || bus.s_ready !== sr || busy !== bz) begin
            errors++;
            $display("FAIL %s t=%0t: got v=%b d=%h l=%b id=%0d rdy=%b busy=%b, want v=%b d=%h l=%b id=%0d rdy=%b busy=%b",
                     name, $time, bus.m_valid, bus.m_data, bus.m_last, bus.m_id, bus.s_ready, busy,
                     mv, md, ml, mid, sr, bz);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // reference model state
    bit              m_busy;
    int              m_own;
    int              m_ptr;
    logic [DW-1:0]   lane_d[N];

    initial begin
        int beat;
        logic [N-1:0] sv, sl, er;
        logic mr, found;

        tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[7]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1};
        tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[10] = '{4'b0100, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[11] = '{4'b0100, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[12] = '{4'b0010, 4'b1111, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[13] = '{4'b0010, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[14] = '{4'b1011, 4'b1111, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};
        tbl[15] = '{4'b1011, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1};

        // reset held with every requester asking
        drive(4'b1111, 4'b1111, 1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 1'b0, '0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        rst_n = 1'b1;

        // fairness rotation, then pointer wrap and skip
        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].sv, tbl[r].sl, tbl[r].mr, r);
            @(negedge clk);
            check($sformatf("table_%0d", r), tbl[r].ev,
                  tbl[r].eb ? lane_word(int'(tbl[r].eid), r) : '0,
                  tbl[r].eb && tbl[r].sl[tbl[r].eid], tbl[r].eid, tbl[r].er, tbl[r].eb);
            next_cycle();
        end
        drive(4'b0000, 4'b0000, 1'b1, 0);
        next_cycle();
        next_cycle();

        // packet lock: requester 2 waits for requester 0's three-beat packet
        drive(4'b0001, 4'b0000, 1'b1, 0);
        @(negedge clk);
        check("lock_idle", 1'b0, '0, 1'b0, 2'd3, 4'b0000, 1'b0);
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            drive(4'b0101, (b == 2) ? 4'b0001 : 4'b0000, 1'b1, b);
            @(negedge clk);
            check($sformatf("lock_beat%0d", b), 1'b1, lane_word(0, b), b == 2, 2'd0, 4'b0001, 1'b1);
            next_cycle();
        end
        drive(4'b0100, 4'b0100, 1'b1, 3);
        @(negedge clk);
        check("lock_bubble", 1'b0, '0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        drive(4'b0100, 4'b0100, 1'b1, 4);
        @(negedge clk);
        check("lock_next", 1'b1, lane_word(2, 4), 1'b1, 2'd2, 4'b0100, 1'b1);
        next_cycle();

        // backpressure: four-beat packet from requester 1 with m_ready toggling
        drive(4'b0010, 4'b0000, 1'b1, 0);
        @(negedge clk);
        check("bp_idle", 1'b0, '0, 1'b0, 2'd2, 4'b0000, 1'b0);
        next_cycle();
        beat = 0;
        for (int c = 0; c < 7; c++) begin
            mr = (c % 2 == 0);
            drive(4'b0010, (beat == 3) ? 4'b0010 : 4'b0000, mr, beat);
            @(negedge clk);
            check($sformatf("bp_cyc%0d", c), 1'b1, lane_word(1, beat), beat == 3, 2'd1,
                  mr ? 4'b0010 : 4'b0000, 1'b1);
            if (bus.m_valid && mr) beat++;
            next_cycle();
        end
        checks++;
        if (beat != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d transfers, want 4", beat);
        end
        drive(4'b0000, 4'b0000, 1'b1, 0);
        @(negedge clk);
        check("bp_done", 1'b0, '0, 1'b0, 2'd1, 4'b0000, 1'b0);
        next_cycle();

        // reset after two of four beats from requester 3
        drive(4'b1000, 4'b0000, 1'b1, 0);
        @(negedge clk);
        check("rmid_idle", 1'b0, '0, 1'b0, 2'd1, 4'b0000, 1'b0);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            drive(4'b1000, 4'b0000, 1'b1, b);
            @(negedge clk);
            check($sformatf("rmid_beat%0d", b), 1'b1, lane_word(3, b), 1'b0, 2'd3, 4'b1000, 1'b1);
            next_cycle();
        end
        drive(4'b1001, 4'b0000, 1'b1, 2);
        rst_n = 1'b0;
        #1;
        check("rmid_reset", 1'b0, '0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rmid_release", 1'b0, '0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rmid_regrant", 1'b1, lane_word(0, 2), 1'b0, 2'd0, 4'b0001, 1'b1);
        next_cycle();

        // random traffic against the reference model
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 0);
        next_cycle();
        rst_n = 1'b1;
        m_busy = 1'b0;
        m_own  = 0;
        m_ptr  = 0;
        for (int c = 0; c < 3000; c++) begin
            sv = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) sl[i] = ($urandom_range(0, 2) == 0);
            mr = ($urandom_range(0, 3) != 0);
            bus.s_valid = sv;
            bus.s_last  = sl;
            bus.m_ready = mr;
            for (int i = 0; i < N; i++) begin
                lane_d[i] = $urandom();
                bus.s_data[i*DW +: DW] = lane_d[i];
            end
            er = '0;
            if (m_busy) er[m_own] = mr;
            @(negedge clk);
            check($sformatf("rand_%0d", c), m_busy && sv[m_own], m_busy ? lane_d[m_own] : '0,
                  m_busy && sl[m_own], IW'(m_own), er, m_busy);
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && sv[(m_ptr + k) % N]) begin
                        m_own  = (m_ptr + k) % N;
                        m_busy = 1'b1;
                        found  = 1'b1;
                    end
                end
            end else if (sv[m_own] && mr && sl[m_own]) begin
                m_ptr  = (m_own + 1) % N;
                m_busy = 1'b0;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
